hdmi_cmd_rx_fsm: RTL and testbench

Parametrised sDCC->DIF command receiver: recovers oversampled serial command frames on `data_in` with a counter/state-machine sampler instead of a full-frame shift register. It re-centres its sampling point on every data transition, so it tolerates drift between transmitter and receiver. It validates sync and check fields and emits a one-cycle `cmd_valid` with the decoded code. It sits on the DIF side directly behind the HDMI-pair input buffer and feeds the command decoder.

---
 rtl/hdmi_cmd_pkg.sv | 21 ++
 rtl/hdmi_cmd_bit_sampler.sv | 56 +++++
 rtl/hdmi_cmd_rx_fsm.sv | 153 +++++++++++++++
 tb/tb_hdmi_cmd_rx_fsm.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_cmd_pkg.sv
// hdmi_cmd_pkg
//   Shared constants and types for the sDCC->DIF command receiver.
//   - Default SYNC / CHK_KEY / IDLE_CODE values (4-bit fields)
//   - Legal oversampling-ratio bounds
//   - Receiver FSM state type
package hdmi_cmd_pkg;

  localparam logic [3:0] SYNC_DEFAULT      = 4'hD;
  localparam logic [3:0] CHK_KEY_DEFAULT   = 4'hD;
  localparam logic [3:0] IDLE_CODE_DEFAULT = 4'hE;

  localparam int unsigned OSR_MIN = 4;
  localparam int unsigned OSR_MAX = 64;

  typedef enum logic [1:0] {
    HUNT,
    CMD,
    CHK
  } rx_state_e;

endpackage

// File: rtl/hdmi_cmd_bit_sampler.sv
// hdmi_cmd_bit_sampler
//   Recovers bit-centre sample points from an oversampled serial line.
//   The phase counter is re-centred on every data transition.
// Ports:
//   clk_50     in   sole clock
//   reset_n    in   asynchronous active-low reset
//   data_in    in   asynchronous serial line
//   sample_stb out  one-cycle strobe at the estimated bit centre
//   sample_bit out  synchronised line value, valid with sample_stb
module hdmi_cmd_bit_sampler
  import hdmi_cmd_pkg::*;
#(
  parameter int unsigned OSR = 10
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic data_in,
  output logic sample_stb,
  output logic sample_bit
);

  localparam int unsigned     PH_W    = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OSR / 2);

  logic            sync1;
  logic            sync2;
  logic            sync3;
  logic            edge_det;
  logic [PH_W-1:0] phase;

  assign edge_det = sync2 ^ sync3;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      phase <= '0;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (edge_det || (phase == PH_LAST)) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  // A transition in the strobe cycle re-centres and suppresses that strobe.
  assign sample_stb = (phase == PH_MID) && !edge_det;
  assign sample_bit = sync2;

endmodule

// File: rtl/hdmi_cmd_rx_fsm.sv
// hdmi_cmd_rx_fsm
//   sDCC->DIF serial command receiver. Hunts for an LSB-first sync field,
//   collects a command field and a check field, and reports the command
//   when check == cmd ^ CHK_KEY.
// Ports:
//   clk_50        in   sole clock (50 MHz)
//   reset_n       in   asynchronous active-low reset
//   data_in       in   asynchronous serial line
//   cmd_code      out  decoded command while cmd_valid, else IDLE_CODE
//   cmd_valid     out  one-cycle pulse per accepted frame
//   frame_aligned out  high while collecting command/check fields
//   cmd_err       out  one-cycle pulse on check mismatch
//   err_cnt       out  saturating mismatch count (HDMI_CMD_RX_ERRCNT_EN only)
// Build option:
//   HDMI_CMD_RX_ERRCNT_EN  adds the ERR_W parameter, err_cnt port and counter
module hdmi_cmd_rx_fsm
  import hdmi_cmd_pkg::*;
#(
  parameter int unsigned          OSR       = 10,
  parameter int unsigned          CMD_W     = 4,
  parameter int unsigned          SYNC_W    = 4,
  parameter logic [SYNC_W-1:0]    SYNC      = SYNC_W'(SYNC_DEFAULT),
  parameter logic [CMD_W-1:0]     CHK_KEY   = CMD_W'(CHK_KEY_DEFAULT),
  parameter logic [CMD_W-1:0]     IDLE_CODE = CMD_W'(IDLE_CODE_DEFAULT)
`ifdef HDMI_CMD_RX_ERRCNT_EN
  ,
  parameter int unsigned          ERR_W     = 8
`endif
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             data_in,
  output logic [CMD_W-1:0] cmd_code,
  output logic             cmd_valid,
  output logic             frame_aligned,
`ifdef HDMI_CMD_RX_ERRCNT_EN
  output logic             cmd_err,
  output logic [ERR_W-1:0] err_cnt
`else
  output logic             cmd_err
`endif
);

  localparam int unsigned      CNT_W    = $clog2(CMD_W + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CMD_W - 1);

  if ((OSR < OSR_MIN) || (OSR > OSR_MAX)) begin : g_osr_range
    $error("hdmi_cmd_rx_fsm: OSR out of range");
  end

  logic              stb;
  logic              sbit;
  rx_state_e         state;
  logic [SYNC_W-1:0] window;
  logic [SYNC_W-1:0] window_nx;
  logic [CMD_W-1:0]  cmd_sr;
  logic [CMD_W-1:0]  chk_sr;
  logic [CMD_W-1:0]  chk_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic              chk_bad;

  hdmi_cmd_bit_sampler #(
    .OSR (OSR)
  ) u_sampler (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .sample_stb (stb),
    .sample_bit (sbit)
  );

  // Fields arrive LSB first, so new bits enter at the MSB.
  assign window_nx = {sbit, window[SYNC_W-1:1]};
  assign chk_nx    = {sbit, chk_sr[CMD_W-1:1]};
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign chk_bad   = (chk_nx != (cmd_sr ^ CHK_KEY));

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HUNT;
      window        <= ~SYNC;
      cmd_sr        <= '0;
      chk_sr        <= '0;
      bit_cnt       <= '0;
      cmd_code      <= IDLE_CODE;
      cmd_valid     <= 1'b0;
      cmd_err       <= 1'b0;
      frame_aligned <= 1'b0;
    end else begin
      cmd_code  <= IDLE_CODE;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (stb) begin
        case (state)
          HUNT: begin
            if (window_nx == SYNC) begin
              state         <= CMD;
              bit_cnt       <= '0;
              frame_aligned <= 1'b1;
            end else begin
              window <= window_nx;
            end
          end
          CMD: begin
            cmd_sr <= {sbit, cmd_sr[CMD_W-1:1]};
            if (last_bit) begin
              state   <= CHK;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          CHK: begin
            chk_sr <= chk_nx;
            if (last_bit) begin
              // Force a full fresh sync field before the next frame.
              state         <= HUNT;
              window        <= ~SYNC;
              bit_cnt       <= '0;
              frame_aligned <= 1'b0;
              if (chk_bad) begin
                cmd_err <= 1'b1;
              end else begin
                cmd_valid <= 1'b1;
                cmd_code  <= cmd_sr;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state         <= HUNT;
            window        <= ~SYNC;
            bit_cnt       <= '0;
            frame_aligned <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef HDMI_CMD_RX_ERRCNT_EN
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (stb && (state == CHK) && last_bit && chk_bad && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_cmd_rx_fsm.sv
// tb_hdmi_cmd_rx_fsm
//   Scoreboard bench for hdmi_cmd_rx_fsm. Two instances: default parameters
//   (4-bit fields, OSR=10) and an 8-bit command variant at OSR=4.
//   Expected pulses are queued by the stimulus; per-instance monitors pop
//   and compare on every cmd_valid/cmd_err pulse.
module tb_hdmi_cmd_rx_fsm;

  logic clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  logic       reset_n = 1'b0;
  logic       data_in = 1'b0;
  logic       data8   = 1'b0;

  logic [3:0] cmd_code;
  logic       cmd_valid;
  logic       frame_aligned;
  logic       cmd_err;
  logic [7:0] cmd_code8;
  logic       cmd_valid8;
  logic       frame_aligned8;
  logic       cmd_err8;
`ifdef HDMI_CMD_RX_ERRCNT_EN
  logic [7:0] err_cnt;
  logic [7:0] err_cnt8;
`endif

  hdmi_cmd_rx_fsm #(
`ifdef HDMI_CMD_RX_ERRCNT_EN
    .ERR_W (8),
`endif
    .OSR   (10),
    .CMD_W (4)
  ) u_dut (
    .clk_50        (clk_50),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .cmd_code      (cmd_code),
    .cmd_valid     (cmd_valid),
    .frame_aligned (frame_aligned),
`ifdef HDMI_CMD_RX_ERRCNT_EN
    .err_cnt       (err_cnt),
`endif
    .cmd_err       (cmd_err)
  );

  hdmi_cmd_rx_fsm #(
`ifdef HDMI_CMD_RX_ERRCNT_EN
    .ERR_W     (8),
`endif
    .OSR       (4),
    .CMD_W     (8),
    .SYNC_W    (4),
    .SYNC      (4'hD),
    .CHK_KEY   (8'hA5),
    .IDLE_CODE (8'hEE)
  ) u_dut8 (
    .clk_50        (clk_50),
    .reset_n       (reset_n),
    .data_in       (data8),
    .cmd_code      (cmd_code8),
    .cmd_valid     (cmd_valid8),
    .frame_aligned (frame_aligned8),
`ifdef HDMI_CMD_RX_ERRCNT_EN
    .err_cnt       (err_cnt8),
`endif
    .cmd_err       (cmd_err8)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] code;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4;
  exp_t e8;
  int   v8_cyc[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect4(input bit is_err, input logic [7:0] code);
    q4.push_back('{is_err: is_err, code: code});
  endtask

  task automatic expect8(input bit is_err, input logic [7:0] code);
    q8.push_back('{is_err: is_err, code: code});
  endtask

  // Monitors: every pulse consumes one scoreboard entry; otherwise the
  // code output must sit at IDLE_CODE.
  always @(negedge clk_50) begin
    if (cmd_valid || cmd_err) begin
      if (q4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut4 unexpected pulse: got valid=%b err=%b code=%h, required no pulse",
                 cmd_valid, cmd_err, cmd_code);
      end else begin
        e4 = q4.pop_front();
        check("dut4 cmd_valid", 32'(cmd_valid), 32'(!e4.is_err));
        check("dut4 cmd_err", 32'(cmd_err), 32'(e4.is_err));
        if (!e4.is_err) check("dut4 cmd_code", 32'(cmd_code), 32'(e4.code[3:0]));
      end
    end else begin
      check("dut4 idle code", 32'(cmd_code), 32'h0E);
    end
  end

  always @(negedge clk_50) begin
    if (cmd_valid8 || cmd_err8) begin
      if (cmd_valid8) v8_cyc.push_back(cyc);
      if (q8.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut8 unexpected pulse: got valid=%b err=%b code=%h, required no pulse",
                 cmd_valid8, cmd_err8, cmd_code8);
      end else begin
        e8 = q8.pop_front();
        check("dut8 cmd_valid", 32'(cmd_valid8), 32'(!e8.is_err));
        check("dut8 cmd_err", 32'(cmd_err8), 32'(e8.is_err));
        if (!e8.is_err) check("dut8 cmd_code", 32'(cmd_code8), 32'(e8.code));
      end
    end else begin
      check("dut8 idle code", 32'(cmd_code8), 32'hEE);
    end
  end

  // Sends one default-width frame; alt selects 9/11 cycles per bit alternately.
  task automatic send4(input logic [3:0] cmd, input logic [3:0] chk, input int cpb, input bit alt);
    logic [11:0] f;
    int          n;
    f = {chk, cmd, 4'hD};
    for (int i = 0; i < 12; i++) begin
      data_in = f[i];
      n = alt ? (((i % 2) == 0) ? 9 : 11) : cpb;
      repeat (n) @(posedge clk_50);
      #1;
    end
  endtask

  task automatic send8(input logic [7:0] cmd, input logic [7:0] chk);
    logic [19:0] f;
    f = {chk, cmd, 4'hD};
    for (int i = 0; i < 20; i++) begin
      data8 = f[i];
      repeat (4) @(posedge clk_50);
      #1;
    end
  endtask

  task automatic idle(input int ncyc);
    data_in = 1'b0;
    data8   = 1'b0;
    repeat (ncyc) @(posedge clk_50);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_50);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [11:0] pf;
    repeat (3) @(posedge clk_50);
    #1;
    check("reset cmd_code", 32'(cmd_code), 32'h0E);
    check("reset cmd_valid", 32'(cmd_valid), 32'h0);
    check("reset cmd_err", 32'(cmd_err), 32'h0);
    check("reset frame_aligned", 32'(frame_aligned), 32'h0);
    check("reset cmd_code8", 32'(cmd_code8), 32'hEE);
`ifdef HDMI_CMD_RX_ERRCNT_EN
    check("reset err_cnt", 32'(err_cnt), 32'h0);
`endif
    reset_n = 1'b1;
    idle(30);

    // Nominal frame at exactly 10 cycles/bit.
    expect4(1'b0, 8'h03);
    send4(4'h3, 4'hE, 10, 1'b0);
    idle(20);

    // Bad check, then a good frame.
    expect4(1'b1, 8'h00);
    send4(4'h3, 4'hF, 10, 1'b0);
    idle(20);
`ifdef HDMI_CMD_RX_ERRCNT_EN
    check("err_cnt after one bad frame", 32'(err_cnt), 32'd1);
`endif
    expect4(1'b0, 8'h05);
    send4(4'h5, 4'h8, 10, 1'b0);
    idle(20);

    // Command equal to IDLE_CODE is still reported.
    expect4(1'b0, 8'h0E);
    send4(4'hE, 4'h3, 10, 1'b0);
    idle(20);

    // Back-to-back frames with no idle bits.
    expect4(1'b0, 8'h06);
    expect4(1'b0, 8'h09);
    send4(4'h6, 4'hB, 10, 1'b0);
    send4(4'h9, 4'h4, 10, 1'b0);
    idle(20);

    // Drifting transmitter: alternating 9/11 cycles per bit, then 11 throughout.
    expect4(1'b0, 8'h0A);
    send4(4'hA, 4'h7, 0, 1'b1);
    idle(20);
    expect4(1'b0, 8'h0A);
    send4(4'hA, 4'h7, 11, 1'b0);
    idle(20);

    // Abort during command bit 2, then a complete fresh frame.
    pf = {4'hA, 4'h7, 4'hD};
    for (int i = 0; i < 6; i++) begin
      data_in = pf[i];
      repeat (10) @(posedge clk_50);
      #1;
    end
    data_in = pf[6];
    repeat (5) @(posedge clk_50);
    #1;
    check("frame_aligned in CMD", 32'(frame_aligned), 32'h1);
    reset_n = 1'b0;
    repeat (2) @(posedge clk_50);
    #1;
    check("frame_aligned in reset", 32'(frame_aligned), 32'h0);
    check("cmd_code in reset", 32'(cmd_code), 32'h0E);
    reset_n = 1'b1;
    idle(30);
    check("frame_aligned hunting after abort", 32'(frame_aligned), 32'h0);
    expect4(1'b0, 8'h01);
    send4(4'h1, 4'hC, 10, 1'b0);
    idle(20);

`ifdef HDMI_CMD_RX_ERRCNT_EN
    // Saturation of the mismatch counter.
    pulse_reset();
    idle(20);
    check("err_cnt cleared", 32'(err_cnt), 32'd0);
    for (int i = 1; i <= 300; i++) begin
      expect4(1'b1, 8'h00);
      send4(4'h3, 4'hF, 10, 1'b0);
      if (i == 254) check("err_cnt after 254", 32'(err_cnt), 32'd254);
      if (i == 255) check("err_cnt after 255", 32'(err_cnt), 32'd255);
      if (i == 256) check("err_cnt after 256", 32'(err_cnt), 32'd255);
    end
    idle(20);
    check("err_cnt after 300", 32'(err_cnt), 32'd255);
`endif

    // 8-bit variant, OSR=4, back-to-back frames.
    expect8(1'b0, 8'h3C);
    expect8(1'b0, 8'hFF);
    send8(8'h3C, 8'h99);
    send8(8'hFF, 8'h5A);
    idle(40);
    check("dut8 valid pulse count", 32'(v8_cyc.size()), 32'd2);
    if (v8_cyc.size() == 2) check("dut8 pulse spacing", 32'(v8_cyc[1] - v8_cyc[0]), 32'd80);

    idle(20);
    check("dut4 scoreboard drained", 32'(q4.size()), 32'd0);
    check("dut8 scoreboard drained", 32'(q8.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
